oddr_x1f: RTL and testbench



---
 rtl/oddr_x1f_if.sv | 9 +
 rtl/oddr_x1f.sv | 47 ++++
 tb/tb_oddr_x1f.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/oddr_x1f_if.sv
// Data/pad bundle for the single-bit output DDR register.
interface oddr_x1f_if;
    logic d0;
    logic d1;
    logic q;

    modport master (output d0, output d1, input q);
    modport slave  (input d0, input d1, output q);
endinterface

// File: rtl/oddr_x1f.sv
// Single-bit output DDR register: d0 shown while SCLK is high, d1 while SCLK is low.
module oddr_x1f #(
    parameter logic RESET_VALUE = 1'b0,
    parameter logic INIT_VALUE  = 1'b0
) (
    input  logic       SCLK,
    input  logic       RST,
    oddr_x1f_if.slave  dio
);

    // Declaration values model the power-up register contents before any clock edge.
    logic d0_q   = INIT_VALUE;
    logic d1_q   = INIT_VALUE;
    logic rst_q  = INIT_VALUE;
    logic d1_n_q = INIT_VALUE;

    logic d0_d;
    logic d1_d;
    logic rst_d;
    logic d1_n_d;

    always_comb begin
        d0_d   = dio.d0;
        d1_d   = dio.d1;
        rst_d  = RST;
        d1_n_d = rst_q ? RESET_VALUE : d1_q;
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            d0_q <= RESET_VALUE;
            d1_q <= RESET_VALUE;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
        end
        rst_q <= rst_d;
    end

    // Retime the second bit so it is stable across the whole low half.
    always_ff @(negedge SCLK) begin
        d1_n_q <= d1_n_d;
    end

    assign dio.q = rst_q ? RESET_VALUE : (SCLK ? d0_q : d1_n_q);

endmodule

// File: tb/tb_oddr_x1f.sv
// Directed scoreboard bench for oddr_x1f: each step queues the expected high/low half values.
module tb_oddr_x1f;

    typedef struct {
        string tag;
        logic  v;
    } exp_t;

    logic SCLK = 1'b0;
    logic RST;
    logic RST1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_q[$];

    oddr_x1f_if dio ();
    oddr_x1f_if dio1 ();

    oddr_x1f u_dut (
        .SCLK (SCLK),
        .RST  (RST),
        .dio  (dio)
    );

    oddr_x1f #(
        .RESET_VALUE (1'b1),
        .INIT_VALUE  (1'b1)
    ) u_dut_rv1 (
        .SCLK (SCLK),
        .RST  (RST1),
        .dio  (dio1)
    );

    always #5 SCLK = ~SCLK;

    task automatic push_exp(input string tag, input logic v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic check_next(input logic obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %b required an expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    // Drive inputs during the low phase, then sample the following high and low halves.
    task automatic step(input logic sel, input logic d0, input logic d1, input logic rst,
                        input logic mid_rst, input logic glitch,
                        input logic hi, input logic lo, input string tag);
        if (sel) begin
            dio1.d0 = d0;
            dio1.d1 = d1;
            RST1    = rst;
        end else begin
            dio.d0 = d0;
            dio.d1 = d1;
            RST    = rst;
        end
        push_exp({tag, "_hi"}, hi);
        push_exp({tag, "_lo"}, lo);
        @(posedge SCLK);
        #2;
        check_next(sel ? dio1.q : dio.q);
        if (sel) RST1 = mid_rst;
        else     RST  = mid_rst;
        if (glitch) begin
            dio.d0 = ~d0;
            dio.d1 = ~d1;
        end
        @(negedge SCLK);
        #2;
        check_next(sel ? dio1.q : dio.q);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST     = 1'b1;
        RST1    = 1'b1;
        dio.d0  = 1'b1;
        dio.d1  = 1'b1;
        dio1.d0 = 1'b0;
        dio1.d1 = 1'b0;

        // Power-up, before the first rising edge.
        #1;
        push_exp("powerup_init0", 1'b0);
        check_next(dio.q);
        push_exp("powerup_init1", 1'b1);
        check_next(dio1.q);

        // Reset hold with data high, then release.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_hold0");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_hold1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_hold2");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rst_release");

        // Alternating DDR pattern and its inverse.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "alt10_a");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "alt10_b");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "alt10_c");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "alt01_a");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "alt01_b");

        // Per-cycle pattern 00, 10, 01, 11, 00.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pat00");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pat10");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "pat01");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "pat11");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pat00b");

        // Reset raised after the falling edge of period k, released mid-period.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "mrst_k");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mrst_k1");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "mrst_resume");
        // Reset raised during the high half leaves the current period intact.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "hrst_k");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "hrst_k1");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "hrst_resume");

        // Inputs toggled between edges and restored before the next edge.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "glitch_a");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "glitch_b");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "glitch_c");

        // RESET_VALUE=1 instance: reset drives both halves high, then normal data.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "rv1_rst0");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "rv1_rst1");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rv1_run");

        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d entries left expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
